// File: rtl/inst_sram_responder_pkg.sv
// Shared types and constants for the inst_sram request interface and its responder.
// The nop constant doubles as the fetch stage's reset/flush instruction.
package inst_sram_responder_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0013;

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } sram_req_t;

    typedef enum logic {
        FILL,
        READY
    } sram_state_e;

endpackage

// File: rtl/inst_sram_responder_sram_array_1rw.sv
// DEPTH x 32 single-port storage: per-byte-lane write enable, registered read.
// The read register holds unless a read or clear is requested.
module sram_array_1rw #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   wdata_i,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Storage has no reset; the responder's fill initialises it.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_clr_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_sram_responder.sv
// Responder for the inst_sram interface: power-on fill FSM, address range check,
// and the fill/request mux in front of a single-port word array.
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter logic [31:0] INIT_WORD = NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sram_en,
    input  logic        sram_wr,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    input  logic [3:0]  sram_wstrb,
    output logic [31:0] sram_rdata,
    output logic        init_done,
    output logic        addr_err
);

    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    sram_req_t   req;
    sram_state_e state_q;
    logic [AW-1:0] fill_idx_q;
    logic        init_done_q;
    logic        addr_err_q;

    logic [31:0]   off;
    logic          in_rng;
    logic [AW-1:0] idx;
    logic          serve;
    logic [AW-1:0] arr_addr;
    logic [3:0]    arr_we;
    logic [31:0]   arr_wdata;
    logic          arr_rd_en;
    logic          arr_rd_clr;
    logic          unused_off_lsbs;

    assign req = '{en: sram_en, wr: sram_wr, addr: sram_addr,
                   wdata: sram_wdata, wstrb: sram_wstrb};

    // Offset wraps, so addresses below BASE_ADDR land far out of range.
    assign off             = req.addr - BASE_ADDR;
    assign in_rng          = (off[31:AW+2] == '0);
    assign idx             = off[AW+1:2];
    assign unused_off_lsbs = ^off[1:0];

    assign serve = (state_q == READY) && !reset && req.en;

    always_comb begin
        arr_addr   = idx;
        arr_we     = '0;
        arr_wdata  = req.wdata;
        arr_rd_en  = 1'b0;
        arr_rd_clr = 1'b0;
        if (state_q == FILL) begin
            arr_addr  = fill_idx_q;
            arr_we    = 4'hF;
            arr_wdata = INIT_WORD;
        end else if (serve) begin
            if (req.wr) begin
                arr_we = in_rng ? req.wstrb : 4'h0;
            end else begin
                arr_rd_en  = in_rng;
                arr_rd_clr = !in_rng;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FILL;
            fill_idx_q  <= '0;
            init_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else if (state_q == FILL) begin
            fill_idx_q <= fill_idx_q + 1'b1;
            addr_err_q <= 1'b0;
            if (fill_idx_q == LAST_IDX) begin
                state_q     <= READY;
                init_done_q <= 1'b1;
            end
        end else begin
            addr_err_q <= req.en && !in_rng;
        end
    end

    sram_array_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i    (clock),
        .rst_i    (reset),
        .addr_i   (arr_addr),
        .we_i     (arr_we),
        .wdata_i  (arr_wdata),
        .rd_en_i  (arr_rd_en),
        .rd_clr_i (arr_rd_clr),
        .rdata_o  (sram_rdata)
    );

    assign init_done = init_done_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder at DEPTH=16: fill timing, strobes,
// streaming reads, range errors, mid-fill reset and misaligned access.
module tb_inst_sram_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        sram_en;
    logic        sram_wr;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_rdata;
    logic        init_done;
    logic        addr_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] last_rd;

    inst_sram_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .INIT_WORD (NOP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sram_en    (sram_en),
        .sram_wr    (sram_wr),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_wstrb (sram_wstrb),
        .sram_rdata (sram_rdata),
        .init_done  (init_done),
        .addr_err   (addr_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        sram_en    = en;
        sram_wr    = wr;
        sram_addr  = addr;
        sram_wdata = wdata;
        sram_wstrb = wstrb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("reset_rdata", sram_rdata, 32'h0);
        chk("reset_init_done", {31'h0, init_done}, 32'h0);
        chk("reset_addr_err", {31'h0, addr_err}, 32'h0);

        // First fill, interrupted by reset after 10 fill cycles.
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        chk("midfill_not_done", {31'h0, init_done}, 32'h0);
        reset = 1'b1;
        tick();
        chk("midreset_not_done", {31'h0, init_done}, 32'h0);

        // Second full fill; early write at fill cycle 5 must be dropped.
        reset = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 6) drive(1'b1, 1'b1, BASE, 32'hFFFF_FFFF, 4'hF);
            else if (i == 7) drive(1'b1, 1'b0, BASE, 32'h0, 4'h0);
            else idle();
            tick();
            chk($sformatf("fill_done_t%0d", i), {31'h0, init_done}, {31'h0, (i == DEPTH)});
            if (i == 6 || i == 7) begin
                chk("early_req_rdata", sram_rdata, 32'h0);
                chk("early_req_err", {31'h0, addr_err}, 32'h0);
            end
        end

        for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOP;

        drive(1'b1, 1'b0, BASE, 32'h0, 4'h0);
        tick();
        chk("word0_after_early_write", sram_rdata, NOP);
        drive(1'b1, 1'b0, BASE + 32'h3C, 32'h0, 4'h0);
        tick();
        chk("fill_last_word", sram_rdata, NOP);

        // Strobed write: rdata holds during the write cycle.
        drive(1'b1, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 4'b0101);
        tick();
        chk("rdata_hold_on_write", sram_rdata, NOP);
        exp_mem[2] = 32'h00AD_00EF;
        drive(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
        tick();
        chk("strobed_read", sram_rdata, 32'h00AD_00EF);

        // wstrb=0 write is a no-op.
        drive(1'b1, 1'b1, BASE + 32'h8, 32'h1111_1111, 4'h0);
        tick();
        drive(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
        tick();
        chk("zero_strobe_noop", sram_rdata, 32'h00AD_00EF);

        // Streaming: write words 1..4, then read back every cycle.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, BASE + 32'(4 * i), 32'(i * 32'h11), 4'hF);
            exp_mem[i] = 32'(i * 32'h11);
            tick();
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0);
            tick();
            chk($sformatf("stream_rd%0d", i), sram_rdata, 32'(i * 32'h11));
        end
        idle();
        tick();
        chk("rdata_hold_idle", sram_rdata, 32'h44);

        // Range errors: below base (wraps) and one past the end.
        drive(1'b1, 1'b0, BASE - 32'h4, 32'h0, 4'h0);
        tick();
        chk("oor_rd_err", {31'h0, addr_err}, 32'h1);
        chk("oor_rd_rdata", sram_rdata, 32'h0);
        drive(1'b1, 1'b1, BASE + 32'(4 * DEPTH), 32'hCAFE_F00D, 4'hF);
        tick();
        chk("oor_wr_err", {31'h0, addr_err}, 32'h1);
        chk("oor_wr_rdata", sram_rdata, 32'h0);
        idle();
        tick();
        chk("err_drops", {31'h0, addr_err}, 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0);
            tick();
            chk($sformatf("readback_w%0d", i), sram_rdata, exp_mem[i]);
            chk($sformatf("readback_err%0d", i), {31'h0, addr_err}, 32'h0);
        end

        // Misaligned write lands on the containing word.
        drive(1'b1, 1'b1, BASE + 32'h6, 32'h1234_5678, 4'hF);
        tick();
        chk("misalign_wr_err", {31'h0, addr_err}, 32'h0);
        drive(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
        tick();
        chk("misalign_rd", sram_rdata, 32'h1234_5678);
        chk("misalign_rd_err", {31'h0, addr_err}, 32'h0);

        // Reset in READY restarts the full fill.
        idle();
        reset = 1'b1;
        tick();
        chk("ready_reset_rdata", sram_rdata, 32'h0);
        chk("ready_reset_done", {31'h0, init_done}, 32'h0);
        reset = 1'b0;
        for (int i = 1; i <= DEPTH; i++) tick();
        chk("refill_done", {31'h0, init_done}, 32'h1);
        drive(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
        tick();
        chk("refill_word1", sram_rdata, NOP);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
